// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// The master modport is the control unit; the slave modport is the datapath side.
interface multicycle_control_unit_if;
  // No handshake: OP/Funct/Zero are level inputs sampled every cycle, and every
  // strobe below is a level output that is valid for the whole current cycle.
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic       PCSrc;
  logic       Illegal_o;
  logic [3:0] State_o;

  modport master (
    input  OP, Funct, Zero,
    output PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, Illegal_o, State_o
  );

  modport slave (
    output OP, Funct, Zero,
    input  PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, Illegal_o, State_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multi-cycle MIPS datapath (lw, sw, beq, addi, R-type).
// Optional macro BNE_EN adds bne (OP 05h) through the shared BRANCH state.
module multicycle_control_unit #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     state_q, state_d;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       op_legal;
  logic       branch_take;

  logic       pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_src, illegal;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    funct_ok  = 1'b0;
    funct_alu = ALU_ADD;
    case (bus.Funct)
      6'h20: begin funct_ok = 1'b1; funct_alu = ALU_ADD; end
      6'h22: begin funct_ok = 1'b1; funct_alu = ALU_SUB; end
      6'h24: begin funct_ok = 1'b1; funct_alu = ALU_AND; end
      6'h25: begin funct_ok = 1'b1; funct_alu = ALU_OR;  end
      6'h27: begin funct_ok = 1'b1; funct_alu = ALU_NOR; end
      6'h2A: begin funct_ok = 1'b1; funct_alu = ALU_SLT; end
      default: ;
    endcase
  end

  // A bad Funct is rejected here so EXECUTE only ever sees supported R-types.
  always_comb begin
    op_legal = 1'b0;
    case (bus.OP)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_legal = 1'b1;
      OP_RTYPE:                      op_legal = funct_ok;
`ifdef BNE_EN
      OP_BNE:                        op_legal = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef BNE_EN
  assign branch_take = (bus.OP == OP_BNE) ? ~bus.Zero : bus.Zero;
`else
  assign branch_take = bus.Zero;
`endif

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    pc_src      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (!op_legal) begin
          illegal = 1'b1;
          state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end else begin
          case (bus.OP)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_ADDI:      state_d = S_ADDIEX;
            default:      state_d = S_BRANCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 1'b1;
        pc_write    = branch_take;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset aborts whatever is in flight without committing any write.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IorD       = iord;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.PCSrc      = pc_src;
  assign bus.Illegal_o  = illegal;
  assign bus.State_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: one instance with ILLEGAL_HALT=0 and one with
// ILLEGAL_HALT=1 share clock, reset and instruction inputs.
module tb_multicycle_control_unit;
  localparam int W = 20;
  localparam logic [3:0] ADD = 4'b0010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if if_d ();
  multicycle_control_unit_if if_h ();

  assign if_h.OP    = if_d.OP;
  assign if_h.Funct = if_d.Funct;
  assign if_h.Zero  = if_d.Zero;

  multicycle_control_unit #(.ILLEGAL_HALT(1'b0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_d.master)
  );

  multicycle_control_unit #(.ILLEGAL_HALT(1'b1)) u_halt (
    .clk   (clk),
    .reset (reset),
    .bus   (if_h.master)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // {state, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, Illegal}
  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic pcw, iord, memw, irw,
                                      rdst, m2r, rw, sa, input logic [1:0] sb,
                                      input logic [3:0] alu, input logic pcsrc, ill);
    return {st, pcw, iord, memw, irw, rdst, m2r, rw, sa, sb, alu, pcsrc, ill};
  endfunction

  function automatic logic [W-1:0] obs_d();
    return {if_d.State_o, if_d.PCWrite, if_d.IorD, if_d.MemWrite, if_d.IRWrite, if_d.RegDst,
            if_d.MemtoReg, if_d.RegWrite, if_d.ALUSrcA, if_d.ALUSrcB, if_d.ALUControl,
            if_d.PCSrc, if_d.Illegal_o};
  endfunction

  function automatic logic [W-1:0] obs_h();
    return {if_h.State_o, if_h.PCWrite, if_h.IorD, if_h.MemWrite, if_h.IRWrite, if_h.RegDst,
            if_h.MemtoReg, if_h.RegWrite, if_h.ALUSrcA, if_h.ALUSrcB, if_h.ALUControl,
            if_h.PCSrc, if_h.Illegal_o};
  endfunction

  function automatic logic [W-1:0] e_fetch();
    return mk(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, ADD, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_decode(input logic ill);
    return mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, ill);
  endfunction
  function automatic logic [W-1:0] e_branch(input logic pcw);
    return mk(4'd8, pcw, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0110, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_halt();
    return mk(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 1);
  endfunction

  task automatic check_cycle(input string name);
    logic [W-1:0] o, e;
    #1;
    o = obs_d();
    e = exp_q.pop_front();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s: state=%0d got=%h expected=%h", name, if_d.State_o, o, e);
    end
    @(negedge clk);
  endtask

  // Entered during a FETCH cycle; pushes the whole expected state walk, then checks it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                           input string name);
    logic [3:0] alu;
    logic       fok;
    if_d.OP    = op;
    if_d.Funct = funct;
    if_d.Zero  = zero;
    fok = 1'b1;
    case (funct)
      6'h20: alu = 4'b0010;
      6'h22: alu = 4'b0110;
      6'h24: alu = 4'b0000;
      6'h25: alu = 4'b0001;
      6'h27: alu = 4'b1100;
      6'h2A: alu = 4'b0111;
      default: begin alu = ADD; fok = 1'b0; end
    endcase
    exp_q.push_back(e_fetch());
    case (op)
      6'h23: begin
        exp_q.push_back(e_decode(0));
        exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 0));
        exp_q.push_back(mk(4'd3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 0));
        exp_q.push_back(mk(4'd4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, ADD, 0, 0));
      end
      6'h2B: begin
        exp_q.push_back(e_decode(0));
        exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 0));
        exp_q.push_back(mk(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 0));
      end
      6'h00: begin
        if (fok) begin
          exp_q.push_back(e_decode(0));
          exp_q.push_back(mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 0, 0));
          exp_q.push_back(mk(4'd7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, ADD, 0, 0));
        end else begin
          exp_q.push_back(e_decode(1));
        end
      end
      6'h04: begin
        exp_q.push_back(e_decode(0));
        exp_q.push_back(e_branch(zero));
      end
`ifdef BNE_EN
      6'h05: begin
        exp_q.push_back(e_decode(0));
        exp_q.push_back(e_branch(~zero));
      end
`endif
      6'h08: begin
        exp_q.push_back(e_decode(0));
        exp_q.push_back(mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 0));
        exp_q.push_back(mk(4'd10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, ADD, 0, 0));
      end
      default: exp_q.push_back(e_decode(1));
    endcase
    while (exp_q.size() > 0) check_cycle(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({if_d.State_o, if_d.PCWrite, if_d.IRWrite, if_d.MemWrite, if_d.RegWrite} !== 8'h00) begin
      bad++;
      $display("FAIL reset_hold: state/enables got=%h expected=00",
               {if_d.State_o, if_d.PCWrite, if_d.IRWrite, if_d.MemWrite, if_d.RegWrite});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs_d() !== e_fetch()) begin
      bad++;
      $display("FAIL reset_release: got=%h expected=%h", obs_d(), e_fetch());
    end
    total++;
    if (obs_h() !== e_fetch()) begin
      bad++;
      $display("FAIL reset_release_halt_inst: got=%h expected=%h", obs_h(), e_fetch());
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6];
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    for (int i = 0; i < 6; i++) run_instr(6'h00, fn[i], $urandom_range(0, 1), "rtype");
  endtask

  task automatic test_halt();
    reset = 1'b1;
    if_d.OP = 6'h3F;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs_h() !== e_fetch()) begin
      bad++;
      $display("FAIL halt_fetch: got=%h expected=%h", obs_h(), e_fetch());
    end
    @(negedge clk);
    #1;
    total++;
    if (obs_h() !== e_decode(1)) begin
      bad++;
      $display("FAIL halt_decode: got=%h expected=%h", obs_h(), e_decode(1));
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if_d.OP = 6'h23;
      #1;
      total++;
      if (obs_h() !== e_halt()) begin
        bad++;
        $display("FAIL halt_park: got=%h expected=%h", obs_h(), e_halt());
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs_h() !== e_fetch()) begin
      bad++;
      $display("FAIL halt_exit: got=%h expected=%h", obs_h(), e_fetch());
    end
    total++;
    if (obs_d() !== e_fetch()) begin
      bad++;
      $display("FAIL halt_exit_main_inst: got=%h expected=%h", obs_d(), e_fetch());
    end
  endtask

  task automatic test_reset_mid_write();
    if_d.OP = 6'h2B;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({if_d.State_o, if_d.MemWrite, if_d.PCWrite, if_d.IRWrite, if_d.RegWrite} !== 8'h50) begin
      bad++;
      $display("FAIL reset_memwrite: state/enables got=%h expected=50",
               {if_d.State_o, if_d.MemWrite, if_d.PCWrite, if_d.IRWrite, if_d.RegWrite});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs_d() !== e_fetch()) begin
      bad++;
      $display("FAIL reset_memwrite_after: got=%h expected=%h", obs_d(), e_fetch());
    end
  endtask

  initial begin
    reset      = 1'b1;
    if_d.OP    = 6'h00;
    if_d.Funct = 6'h20;
    if_d.Zero  = 1'b0;
    test_reset();
    run_instr(6'h23, 6'h00, 1'b0, "lw");
    run_instr(6'h2B, 6'h00, 1'b1, "sw");
    test_rtype();
    run_instr(6'h08, 6'h3F, 1'b0, "addi");
    run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
    run_instr(6'h04, 6'h00, 1'b0, "beq_not_taken");
    run_instr(6'h05, 6'h00, 1'b0, "bne_zero0");
    run_instr(6'h05, 6'h00, 1'b1, "bne_zero1");
    run_instr(6'h3F, 6'h20, 1'b0, "illegal_op");
    run_instr(6'h00, 6'h3F, 1'b0, "illegal_funct");
    run_instr(6'h00, 6'h20, 1'b0, "after_illegal");
    test_halt();
    test_reset_mid_write();
    run_instr(6'h23, 6'h00, 1'b0, "lw_after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
